// File: rtl/ascii_string_n_if.sv
// Pixel-side bus for the ascii_string_n overlay: scan position, string load and glyph lookup results.
interface ascii_string_n_if #(
  parameter int unsigned NUM_CHARS = 48,
  parameter int unsigned CHAR_W    = 8
);
  localparam int unsigned COL_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;

  logic                   frame_start;
  logic [9:0]             DrawX;
  logic [9:0]             DrawY;
  logic [10:0]            shape_x;
  logic [10:0]            shape_y;
  logic [8*NUM_CHARS-1:0] input_string_in;
  logic                   load_string;
  logic [1:0]             mode;
  logic                   sprite_on;
  logic [10:0]            sprite_addr;
  logic [10:0]            u_shape_x;
  logic [10:0]            u_shape_y;
  logic [COL_W-1:0]       glyph_col;
  logic                   load_pending;

  modport master (
    output frame_start, DrawX, DrawY, shape_x, shape_y,
           input_string_in, load_string, mode,
    input  sprite_on, sprite_addr, u_shape_x, u_shape_y, glyph_col, load_pending
  );

  modport slave (
    input  frame_start, DrawX, DrawY, shape_x, shape_y,
           input_string_in, load_string, mode,
    output sprite_on, sprite_addr, u_shape_x, u_shape_y, glyph_col, load_pending
  );
endinterface

// File: rtl/ascii_string_n.sv
// Text-string sprite generator: double-buffered string, per-frame scroll/blink, and a
// registered font-ROM address for the pixel under the scan position.
module ascii_string_n #(
  parameter int unsigned NUM_CHARS  = 48,
  parameter int unsigned CHAR_W     = 8,
  parameter int unsigned CHAR_H     = 16,
  parameter int unsigned SCROLL_DIV = 8,
  parameter int unsigned BLINK_DIV  = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  ascii_string_n_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int unsigned COL_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int unsigned SD_W  = $clog2(SCROLL_DIV + 1);
  localparam int unsigned BD_W  = $clog2(BLINK_DIV + 1);
  localparam logic [11:0] BOX_W = 12'(NUM_CHARS * CHAR_W);
  localparam logic [11:0] BOX_H = 12'(CHAR_H);

  logic [7:0]       r_active [NUM_CHARS];
  logic [7:0]       r_shadow [NUM_CHARS];
  logic             r_load_pending;
  logic [BD_W-1:0]  r_blink_cnt;
  logic             r_blink_phase;
  logic [SD_W-1:0]  r_scroll_cnt;
  logic [IDX_W-1:0] r_offset;
  logic             r_sprite_on;
  logic [10:0]      r_sprite_addr;
  logic [10:0]      r_u_shape_x;
  logic [10:0]      r_u_shape_y;
  logic [COL_W-1:0] r_glyph_col;

  logic             w_commit;
  logic [11:0]      w_x;
  logic [11:0]      w_y;
  logic [11:0]      w_sx;
  logic [11:0]      w_sy;
  logic [11:0]      w_dx;
  logic [11:0]      w_dy;
  logic [11:0]      w_cell;
  logic [12:0]      w_sum;
  logic [12:0]      w_eff;
  logic             w_in_box;
  logic [7:0]       w_code;
  logic             w_on;

  assign w_commit = bus.frame_start && r_load_pending;

  // Shadow capture happens after the commit so a same-cycle load lands in shadow and stays pending.
  always_ff @(posedge Clk or negedge Reset) begin : buf_p
    if (!Reset) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        r_active[i] <= 8'h00;
        r_shadow[i] <= 8'h00;
      end
      r_load_pending <= 1'b0;
    end else begin
      if (w_commit) begin
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_load_pending <= 1'b0;
      end
      if (bus.load_string) begin
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
          r_shadow[i] <= bus.input_string_in[8*(int'(NUM_CHARS)-1-i) +: 8];
        end
        r_load_pending <= 1'b1;
      end
    end
  end

  // Per-frame blink phase and scroll offset; a commit restarts scrolling from the first char.
  always_ff @(posedge Clk or negedge Reset) begin : frame_p
    if (!Reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_scroll_cnt  <= '0;
      r_offset      <= '0;
    end else if (bus.frame_start) begin
      if (r_blink_cnt == BD_W'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BD_W'(1);
      end

      if (w_commit || !bus.mode[1]) begin
        r_scroll_cnt <= '0;
        r_offset     <= '0;
      end else if (r_scroll_cnt == SD_W'(SCROLL_DIV - 1)) begin
        r_scroll_cnt <= '0;
        r_offset     <= (r_offset == IDX_W'(NUM_CHARS - 1)) ? '0 : r_offset + IDX_W'(1);
      end else begin
        r_scroll_cnt <= r_scroll_cnt + SD_W'(1);
      end
    end
  end

  // Box test in 12 bits so a box ending past 2047 does not wrap.
  assign w_x      = {2'b00, bus.DrawX};
  assign w_y      = {2'b00, bus.DrawY};
  assign w_sx     = {1'b0, bus.shape_x};
  assign w_sy     = {1'b0, bus.shape_y};
  assign w_dx     = w_x - w_sx;
  assign w_dy     = w_y - w_sy;
  assign w_in_box = (w_x >= w_sx) && (w_x < w_sx + BOX_W) &&
                    (w_y >= w_sy) && (w_y < w_sy + BOX_H);
  assign w_cell   = w_dx / 12'(CHAR_W);
  assign w_sum    = {1'b0, w_cell} + 13'(r_offset);
  assign w_eff    = (w_sum >= 13'(NUM_CHARS)) ? w_sum - 13'(NUM_CHARS) : w_sum;

  always_comb begin : code_c
    w_code = 8'h00;
    if (w_eff < 13'(NUM_CHARS)) begin
      w_code = r_active[IDX_W'(w_eff)];
    end
  end

  assign w_on = w_in_box && (w_code != 8'h00) && !(bus.mode[0] && r_blink_phase);

  always_ff @(posedge Clk or negedge Reset) begin : out_p
    if (!Reset) begin
      r_sprite_on   <= 1'b0;
      r_sprite_addr <= '0;
      r_glyph_col   <= '0;
      r_u_shape_x   <= '0;
      r_u_shape_y   <= '0;
    end else begin
      r_sprite_on   <= w_on;
      r_sprite_addr <= w_on ? 11'(32'(w_code) * CHAR_H + 32'(w_dy)) : 11'd0;
      r_glyph_col   <= w_on ? COL_W'(w_dx % 12'(CHAR_W)) : '0;
      r_u_shape_x   <= bus.shape_x;
      r_u_shape_y   <= bus.shape_y;
    end
  end

  assign bus.sprite_on    = r_sprite_on;
  assign bus.sprite_addr  = r_sprite_addr;
  assign bus.glyph_col    = r_glyph_col;
  assign bus.u_shape_x    = r_u_shape_x;
  assign bus.u_shape_y    = r_u_shape_y;
  assign bus.load_pending = r_load_pending;

endmodule
